// File: rtl/pcw_mem_pkg.sv
// rtl/pcw_mem_pkg.sv - shared types and constants for the video/CPU memory arbiter
package pcw_mem_pkg;

  typedef enum logic [1:0] {
    C_IDLE,
    C_WAIT,
    C_ACK
  } cpu_state_t;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_VID,
    TAG_CPU
  } mem_tag_t;

  localparam logic [1:0] PH_VID = 2'd0;

endpackage

// File: rtl/mem_tag_pipe.sv
// rtl/mem_tag_pipe.sv - DEPTH-deep shift register of return tags, one per memory cycle
module mem_tag_pipe
  import pcw_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  mem_tag_t i_tag,
  output mem_tag_t o_tag
);

  mem_tag_t r_stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= TAG_NONE;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/video_mem_arbiter.sv
// rtl/video_mem_arbiter.sv - shares one pipelined memory port between video slot reads and CPU accesses
module video_mem_arbiter
  import pcw_mem_pkg::*;
#(
  parameter int ADDR_W      = 17,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              vid_stb,
  input  logic              vid_en,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_dout,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  logic [1:0]        r_phase;
  cpu_state_t        r_state;
  mem_tag_t          r_issue_tag;
  mem_tag_t          w_ret_tag;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_re;
  logic              r_mem_we;
  logic [7:0]        r_mem_wdata;
  logic [7:0]        r_vid_dout;
  logic [7:0]        r_cpu_rdata;
  logic              r_cpu_ack;
  logic [1:0]        w_phase;
  logic              w_vid_issue;
  logic              w_cpu_issue;

  // A strobe means "this is phase 0" regardless of where the counter drifted.
  assign w_phase     = vid_stb ? PH_VID : r_phase;
  assign w_vid_issue = (w_phase == PH_VID) && vid_en;
  assign w_cpu_issue = (r_state == C_IDLE) && cpu_req && !w_vid_issue;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= 2'd0;
    end else begin
      r_phase <= vid_stb ? 2'd1 : r_phase + 2'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_addr  <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= 8'd0;
      r_issue_tag <= TAG_NONE;
    end else begin
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_issue_tag <= TAG_NONE;
      if (w_vid_issue) begin
        r_mem_addr  <= vid_addr;
        r_mem_re    <= 1'b1;
        r_issue_tag <= TAG_VID;
      end else if (w_cpu_issue) begin
        r_mem_addr <= cpu_addr;
        if (cpu_we) begin
          r_mem_we    <= 1'b1;
          r_mem_wdata <= cpu_wdata;
        end else begin
          r_mem_re    <= 1'b1;
          r_issue_tag <= TAG_CPU;
        end
      end
    end
  end

  // Tag enters alongside the command on the bus, so it emerges with its data.
  mem_tag_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_tag_pipe (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .i_tag (r_issue_tag),
    .o_tag (w_ret_tag)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_vid_dout <= 8'd0;
    end else if (w_ret_tag == TAG_VID) begin
      r_vid_dout <= mem_rdata;
    end
  end

  // In C_ACK a write first arms the ack; a read arrives with it already high.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= C_IDLE;
      r_cpu_ack   <= 1'b0;
      r_cpu_rdata <= 8'd0;
    end else begin
      case (r_state)
        C_IDLE: begin
          r_cpu_ack <= 1'b0;
          if (w_cpu_issue) r_state <= cpu_we ? C_ACK : C_WAIT;
        end
        C_WAIT: begin
          if (w_ret_tag == TAG_CPU) begin
            r_cpu_rdata <= mem_rdata;
            r_cpu_ack   <= 1'b1;
            r_state     <= C_ACK;
          end
        end
        C_ACK: begin
          if (r_cpu_ack) begin
            r_cpu_ack <= 1'b0;
            r_state   <= C_IDLE;
          end else begin
            r_cpu_ack <= 1'b1;
          end
        end
        default: begin
          r_cpu_ack <= 1'b0;
          r_state   <= C_IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign vid_dout  = r_vid_dout;
  assign cpu_ack   = r_cpu_ack;
  assign cpu_rdata = r_cpu_rdata;

endmodule

// File: tb/tb_video_mem_arbiter.sv
// tb/tb_video_mem_arbiter.sv - self-checking bench for video_mem_arbiter
module tb_video_mem_arbiter;

  localparam int AW = 17;
  localparam int L  = 2;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          vid_stb;
  logic          vid_en;
  logic [AW-1:0] vid_addr;
  logic [7:0]    vid_dout;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic          cpu_we;
  logic [7:0]    cpu_wdata;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  int         checks;
  int         failures;
  logic [1:0] ph;
  logic [7:0] h1, h2;
  logic [7:0] exp_vid;
  logic [7:0] exp_rdata;

  always #5 clk_sys = ~clk_sys;

  video_mem_arbiter #(
    .ADDR_W      (AW),
    .MEM_LATENCY (L)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .vid_stb   (vid_stb),
    .vid_en    (vid_en),
    .vid_addr  (vid_addr),
    .vid_dout  (vid_dout),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // One cycle: memory model answers reads with addr[7:0] L cycles later (garbage otherwise),
  // and the reference phase follows the strobe/resync rule.
  task automatic step();
    logic [1:0] nxt;
    @(negedge clk_sys);
    mem_rdata = h2;
    h2 = h1;
    h1 = mem_re ? mem_addr[7:0] : 8'($urandom);
    nxt = vid_stb ? 2'd1 : ph + 2'd1;
    @(posedge clk_sys);
    #1;
    ph = reset_n ? nxt : 2'd0;
  endtask

  task automatic align(input logic [1:0] p);
    for (int i = 0; i < 4 && ph != p; i++) step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vid_stb = 1'($urandom); vid_en = 1'($urandom); vid_addr = AW'($urandom);
      cpu_req = 1'($urandom); cpu_addr = AW'($urandom); cpu_we = 1'($urandom);
      cpu_wdata = 8'($urandom);
      step();
      checks++;
      if ({mem_re, mem_we, mem_addr, mem_wdata, vid_dout, cpu_ack, cpu_rdata} !== '0) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: re=%b we=%b addr=%h wdata=%h vid=%h ack=%b rdata=%h, required all zero",
                 i, mem_re, mem_we, mem_addr, mem_wdata, vid_dout, cpu_ack, cpu_rdata);
      end
    end
    vid_stb = 0; vid_en = 0; vid_addr = '0; cpu_req = 0; cpu_addr = '0; cpu_we = 0; cpu_wdata = 0;
    reset_n = 1'b1;
    ph = 2'd0;
    exp_vid = 8'd0;
    exp_rdata = 8'd0;
  endtask

  task automatic test_video_read();
    logic [AW-1:0] a, b;
    vid_en = 1'b1;
    for (int n = 0; n < 4; n++) begin
      a = (n == 0) ? AW'(17'h01234) : AW'($urandom);
      align(2'd0);
      vid_addr = a; vid_stb = 1'b1;
      step();
      vid_stb = 1'b0;
      checks++;
      if (!(mem_re === 1'b1 && mem_we === 1'b0 && mem_addr === a)) begin
        failures++;
        $display("FAIL video_issue: re=%b we=%b addr=%h, required re=1 we=0 addr=%h", mem_re, mem_we, mem_addr, a);
      end
      b = AW'($urandom);
      vid_addr = b;
      step(); step(); step();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (vid_dout !== a[7:0]) begin
          failures++;
          $display("FAIL video_dout T+%0d: got %h, required %h", 4 + k, vid_dout, a[7:0]);
        end
        step();
      end
      checks++;
      if (vid_dout !== b[7:0]) begin
        failures++;
        $display("FAIL video_next_slot: got %h, required %h", vid_dout, b[7:0]);
      end
    end
  endtask

  task automatic test_cpu_collide();
    logic [AW-1:0] a, v;
    vid_en = 1'b1;
    for (int n = 0; n < 4; n++) begin
      a = (n == 0) ? AW'(17'h00055) : AW'($urandom);
      v = AW'($urandom);
      align(2'd0);
      vid_addr = v; cpu_addr = a; cpu_we = 1'b0; cpu_wdata = 8'($urandom); cpu_req = 1'b1;
      step();
      checks++;
      if (!(mem_re === 1'b1 && mem_addr === v && cpu_ack === 1'b0)) begin
        failures++;
        $display("FAIL collide_video_first: re=%b addr=%h ack=%b, required re=1 addr=%h ack=0", mem_re, mem_addr, cpu_ack, v);
      end
      step();
      checks++;
      if (!(mem_re === 1'b1 && mem_we === 1'b0 && mem_addr === a && cpu_ack === 1'b0)) begin
        failures++;
        $display("FAIL collide_cpu_issue: re=%b we=%b addr=%h ack=%b, required re=1 we=0 addr=%h ack=0",
                 mem_re, mem_we, mem_addr, cpu_ack, a);
      end
      step();
      checks++;
      if (cpu_ack !== 1'b0) begin
        failures++;
        $display("FAIL collide_early_ack I+1: ack=%b, required 0", cpu_ack);
      end
      step();
      checks++;
      if (!(cpu_ack === 1'b0 && vid_dout === v[7:0])) begin
        failures++;
        $display("FAIL collide_video_intact: ack=%b vid=%h, required ack=0 vid=%h", cpu_ack, vid_dout, v[7:0]);
      end
      step();
      checks++;
      if (!(cpu_ack === 1'b1 && cpu_rdata === a[7:0])) begin
        failures++;
        $display("FAIL collide_ack: ack=%b rdata=%h, required ack=1 rdata=%h", cpu_ack, cpu_rdata, a[7:0]);
      end
      cpu_req = 1'b0;
      exp_rdata = a[7:0];
      step();
      checks++;
      if (!(cpu_ack === 1'b0 && cpu_rdata === exp_rdata)) begin
        failures++;
        $display("FAIL collide_after_ack: ack=%b rdata=%h, required ack=0 rdata=%h", cpu_ack, cpu_rdata, exp_rdata);
      end
    end
  endtask

  task automatic test_cpu_write();
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic [1:0]    p;
    vid_en = 1'b1;
    vid_addr = AW'($urandom);
    repeat (8) step();
    exp_vid = vid_addr[7:0];
    for (int n = 0; n < 4; n++) begin
      p = (n == 0) ? 2'd2 : 2'($urandom_range(1, 3));
      a = (n == 0) ? AW'(17'h1FFFF) : AW'($urandom);
      d = (n == 0) ? 8'hA5 : 8'($urandom);
      align(p);
      cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1; cpu_req = 1'b1;
      step();
      checks++;
      if (!(mem_we === 1'b1 && mem_re === 1'b0 && mem_addr === a && mem_wdata === d && cpu_ack === 1'b0)) begin
        failures++;
        $display("FAIL write_issue ph%0d: we=%b re=%b addr=%h wdata=%h ack=%b, required we=1 re=0 addr=%h wdata=%h ack=0",
                 p, mem_we, mem_re, mem_addr, mem_wdata, cpu_ack, a, d);
      end
      step();
      checks++;
      if (!(cpu_ack === 1'b1 && mem_we === 1'b0 && vid_dout === exp_vid && cpu_rdata === exp_rdata)) begin
        failures++;
        $display("FAIL write_ack: ack=%b we=%b vid=%h rdata=%h, required ack=1 we=0 vid=%h rdata=%h",
                 cpu_ack, mem_we, vid_dout, cpu_rdata, exp_vid, exp_rdata);
      end
      cpu_req = 1'b0;
      step();
    end
  endtask

  task automatic test_video_disabled();
    logic [AW-1:0] a;
    vid_en = 1'b0;
    repeat (6) step();
    exp_vid = vid_addr[7:0];
    for (int n = 0; n < 3; n++) begin
      a = AW'($urandom);
      align(2'd0);
      vid_addr = AW'($urandom);
      cpu_addr = a; cpu_we = 1'b0; cpu_req = 1'b1;
      step();
      checks++;
      if (!(mem_re === 1'b1 && mem_addr === a && vid_dout === exp_vid)) begin
        failures++;
        $display("FAIL viddis_issue: re=%b addr=%h vid=%h, required re=1 addr=%h vid=%h", mem_re, mem_addr, vid_dout, a, exp_vid);
      end
      step(); step(); step();
      checks++;
      if (!(cpu_ack === 1'b1 && cpu_rdata === a[7:0] && vid_dout === exp_vid)) begin
        failures++;
        $display("FAIL viddis_ack: ack=%b rdata=%h vid=%h, required ack=1 rdata=%h vid=%h",
                 cpu_ack, cpu_rdata, vid_dout, a[7:0], exp_vid);
      end
      cpu_req = 1'b0;
      exp_rdata = a[7:0];
      step();
    end
  endtask

  task automatic test_resync();
    logic [AW-1:0] v, w;
    logic [1:0]    p;
    vid_en = 1'b1;
    cpu_req = 1'b0;
    for (int n = 0; n < 3; n++) begin
      p = (n == 0) ? 2'd2 : ((n == 1) ? 2'd1 : 2'd3);
      align(p);
      v = AW'($urandom);
      vid_addr = v; vid_stb = 1'b1;
      step();
      vid_stb = 1'b0;
      checks++;
      if (!(mem_re === 1'b1 && mem_addr === v)) begin
        failures++;
        $display("FAIL resync_issue ph%0d: re=%b addr=%h, required re=1 addr=%h", p, mem_re, mem_addr, v);
      end
      w = AW'($urandom);
      vid_addr = w;
      for (int k = 2; k <= 4; k++) begin
        step();
        checks++;
        if (mem_re !== 1'b0) begin
          failures++;
          $display("FAIL resync_no_dup T+%0d: re=%b, required 0", k, mem_re);
        end
      end
      checks++;
      if (vid_dout !== v[7:0]) begin
        failures++;
        $display("FAIL resync_dout: got %h, required %h", vid_dout, v[7:0]);
      end
      step();
      checks++;
      if (!(mem_re === 1'b1 && mem_addr === w)) begin
        failures++;
        $display("FAIL resync_next_slot: re=%b addr=%h, required re=1 addr=%h", mem_re, mem_addr, w);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [AW-1:0] a;
    vid_en = 1'b0;
    repeat (4) step();
    align(2'd1);
    a = AW'($urandom) | AW'(1);
    cpu_addr = a; cpu_we = 1'b0; cpu_req = 1'b1;
    step();
    checks++;
    if (!(mem_re === 1'b1 && mem_addr === a)) begin
      failures++;
      $display("FAIL midrst_issue: re=%b addr=%h, required re=1 addr=%h", mem_re, mem_addr, a);
    end
    step();
    reset_n = 1'b0;
    cpu_req = 1'b0;
    step();
    reset_n = 1'b1;
    exp_vid = 8'd0;
    exp_rdata = 8'd0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (!(cpu_ack === 1'b0 && cpu_rdata === 8'd0 && vid_dout === 8'd0)) begin
        failures++;
        $display("FAIL midrst_discard cycle %0d: ack=%b rdata=%h vid=%h, required all zero", k, cpu_ack, cpu_rdata, vid_dout);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic          we;
    logic          seen;
    int            lat, got;
    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 3)) step();
      a = AW'($urandom); d = 8'($urandom); we = 1'($urandom);
      vid_en = 1'($urandom); vid_addr = AW'($urandom);
      cpu_addr = a; cpu_wdata = d; cpu_we = we; cpu_req = 1'b1;
      lat = (we ? 2 : L + 2) + ((ph == 2'd0 && vid_en) ? 1 : 0);
      got = 0;
      seen = 1'b0;
      for (int k = 1; k <= 8 && got == 0; k++) begin
        step();
        if (mem_we && mem_addr == a && mem_wdata == d) seen = 1'b1;
        if (cpu_ack) got = k;
      end
      checks++;
      if (got != lat) begin
        failures++;
        $display("FAIL b2b_latency #%0d we=%b: ack after %0d cycles, required %0d", n, we, got, lat);
      end
      checks++;
      if (we ? !seen : (cpu_rdata !== a[7:0])) begin
        failures++;
        $display("FAIL b2b_data #%0d we=%b: write_seen=%b rdata=%h, required write_seen=1 or rdata=%h",
                 n, we, seen, cpu_rdata, a[7:0]);
      end
      cpu_req = 1'b0;
      step();
      checks++;
      if (cpu_ack !== 1'b0) begin
        failures++;
        $display("FAIL b2b_single_pulse #%0d: ack=%b, required 0", n, cpu_ack);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0; ph = 2'd0; h1 = 8'd0; h2 = 8'd0; mem_rdata = 8'd0;
    exp_vid = 8'd0; exp_rdata = 8'd0;
    reset_n = 1'b0; vid_stb = 0; vid_en = 0; vid_addr = '0;
    cpu_req = 0; cpu_addr = '0; cpu_we = 0; cpu_wdata = 0;
    #1;
    test_reset();
    test_video_read();
    test_cpu_collide();
    test_cpu_write();
    test_video_disabled();
    test_resync();
    test_reset_mid_read();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
